// File: rtl/otp_keystream_gen.sv
// One-time-pad key byte generator: a 16-bit Galois LFSR stepped one bit per clock,
// packing eight output bits (LSB first) into a byte offered on a valid/ready handshake.
module otp_keystream_gen #(
    parameter logic [15:0] LFSR_POLY    = 16'hB400,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        seed_load_i,
    input  logic [15:0] seed_i,
    input  logic        enable_i,
    input  logic        key_ready_i,
    output logic [7:0]  key_out_o,
    output logic        key_valid_o,
    output logic        busy_o,
    output logic [15:0] byte_count_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGen  = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [7:0]  key_out_q;
    logic        key_valid_q;
    logic        busy_q;
    logic [15:0] byte_count_q;

    // Next LFSR state and the byte with the current output bit merged in.
    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
        shift_d = shift_q;
        shift_d[bit_cnt_q] = lfsr_q[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            lfsr_q       <= DEFAULT_SEED;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            key_out_q    <= 8'h00;
            key_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            byte_count_q <= 16'h0000;
        end else if (seed_load_i) begin
            // Resync: a partial or pending byte is discarded; key_out keeps its stale value.
            state_q      <= StIdle;
            lfsr_q       <= (seed_i == 16'h0000) ? DEFAULT_SEED : seed_i;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            key_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            byte_count_q <= 16'h0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable_i) begin
                        state_q <= StGen;
                        busy_q  <= 1'b1;
                    end
                end
                StGen: begin
                    lfsr_q    <= lfsr_d;
                    shift_q   <= shift_d;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        key_out_q   <= shift_d;
                        key_valid_q <= 1'b1;
                        state_q     <= StHold;
                        busy_q      <= 1'b0;
                        bit_cnt_q   <= 3'd0;
                    end
                end
                StHold: begin
                    if (key_ready_i) begin
                        key_valid_q  <= 1'b0;
                        byte_count_q <= byte_count_q + 16'd1;
                        state_q      <= enable_i ? StGen : StIdle;
                        busy_q       <= enable_i;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign key_out_o    = key_out_q;
    assign key_valid_o  = key_valid_q;
    assign busy_o       = busy_q;
    assign byte_count_o = byte_count_q;

endmodule

// File: tb/tb_otp_keystream_gen.sv
// Directed bench for otp_keystream_gen, including an encrypt/decrypt loopback with a
// second generator instance sharing the same seed.
module tb_otp_keystream_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        enable = 1'b0;
    logic        key_ready = 1'b0;
    logic [7:0]  key_out;
    logic        key_valid;
    logic        busy;
    logic [15:0] byte_count;

    logic        rx_seed_load = 1'b0;
    logic [15:0] rx_seed = 16'h0000;
    logic        rx_enable = 1'b0;
    logic [7:0]  rx_key_out;
    logic        rx_key_valid;
    logic        rx_busy;
    logic [15:0] rx_byte_count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    otp_keystream_gen u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .seed_load_i (seed_load),
        .seed_i      (seed),
        .enable_i    (enable),
        .key_ready_i (key_ready),
        .key_out_o   (key_out),
        .key_valid_o (key_valid),
        .busy_o      (busy),
        .byte_count_o(byte_count)
    );

    otp_keystream_gen u_rx (
        .clk_i       (clk),
        .rst_i       (rst),
        .seed_load_i (rx_seed_load),
        .seed_i      (rx_seed),
        .enable_i    (rx_enable),
        .key_ready_i (1'b0),
        .key_out_o   (rx_key_out),
        .key_valid_o (rx_key_valid),
        .busy_o      (rx_busy),
        .byte_count_o(rx_byte_count)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until key_valid is seen, bounded so a stuck DUT shows up as a bad count.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!key_valid && cycles < 40);
    endtask

    initial begin
        int   c;
        logic seen;
        logic [7:0] cipher;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", {15'd0, key_valid}, 16'd0);
        check("rst_key", {8'd0, key_out}, 16'h0000);
        check("rst_count", byte_count, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);

        // First byte: 8 GEN cycles after the IDLE->GEN edge
        enable = 1'b1;
        tick();
        check("gen_busy", {15'd0, busy}, 16'd1);
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            seen = seen | key_valid;
        end
        check("no_early_valid", {15'd0, seen}, 16'd0);
        tick();
        check("first_valid", {15'd0, key_valid}, 16'd1);
        check("first_byte", {8'd0, key_out}, 16'h00E1);
        check("hold_busy", {15'd0, busy}, 16'd0);

        // Stall in HOLD for 20 cycles
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (key_out !== 8'hE1 || key_valid !== 1'b1) seen = 1'b1;
        end
        check("hold_stable", {15'd0, seen}, 16'd0);
        check("hold_count", byte_count, 16'd0);

        // One transfer, then idle
        enable = 1'b0;
        key_ready = 1'b1;
        tick();
        check("xfer_valid", {15'd0, key_valid}, 16'd0);
        check("xfer_count", byte_count, 16'd1);
        tick();
        tick();
        check("xfer_once", byte_count, 16'd1);
        check("idle_busy", {15'd0, busy}, 16'd0);

        // Second byte comes from LFSR 16'hC2C4
        key_ready = 1'b0;
        enable = 1'b1;
        wait_valid(c);
        check("byte2_lat", c[15:0], 16'd9);
        check("byte2", {8'd0, key_out}, 16'h00C4);

        // seed_load with key_ready=1 in HOLD drops the pending byte
        seed = 16'hACE1;
        seed_load = 1'b1;
        key_ready = 1'b1;
        tick();
        seed_load = 1'b0;
        check("drop_valid", {15'd0, key_valid}, 16'd0);
        check("drop_count", byte_count, 16'd0);

        // Back-to-back stream: E1, C4, 62 nine clocks apart
        wait_valid(c);
        check("bb1_lat", c[15:0], 16'd9);
        check("bb1", {8'd0, key_out}, 16'h00E1);
        wait_valid(c);
        check("bb2_gap", c[15:0], 16'd9);
        check("bb2", {8'd0, key_out}, 16'h00C4);
        wait_valid(c);
        check("bb3_gap", c[15:0], 16'd9);
        check("bb3", {8'd0, key_out}, 16'h0062);
        check("bb3_count", byte_count, 16'd2);
        tick();
        check("bb3_xfer_count", byte_count, 16'd3);

        // Zero seed falls back to the default seed
        key_ready = 1'b0;
        seed = 16'h0000;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        wait_valid(c);
        check("zero_seed", {8'd0, key_out}, 16'h00E1);

        // Abort mid-byte at bit_cnt=4
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("restart_busy", {15'd0, busy}, 16'd1);
        check("restart_count", byte_count, 16'd1);
        for (int i = 0; i < 4; i++) tick();
        seed = 16'h1234;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_valid", {15'd0, key_valid}, 16'd0);
        check("abort_count", byte_count, 16'd0);
        wait_valid(c);
        check("abort_lat", c[15:0], 16'd9);
        check("abort_byte", {8'd0, key_out}, 16'h0034);

        // seed_load beats a same-cycle transfer
        enable = 1'b0;
        key_ready = 1'b1;
        seed = 16'hACE1;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        tick();
        check("hold_drop_valid", {15'd0, key_valid}, 16'd0);
        check("hold_drop_count", byte_count, 16'd0);

        // Loopback: encrypt with u_dut, decrypt with u_rx
        key_ready = 1'b0;
        enable = 1'b1;
        wait_valid(c);
        cipher = 8'h5A ^ key_out;
        check("encrypt", {8'd0, cipher}, 16'h00BB);
        rx_seed = 16'hACE1;
        rx_seed_load = 1'b1;
        tick();
        rx_seed_load = 1'b0;
        rx_enable = 1'b1;
        c = 0;
        do begin
            tick();
            c++;
        end while (!rx_key_valid && c < 40);
        check("rx_lat", c[15:0], 16'd9);
        check("decrypt", {8'd0, cipher ^ rx_key_out}, 16'h005A);

        // rst outranks seed_load
        rst = 1'b1;
        seed = 16'h1234;
        seed_load = 1'b1;
        tick();
        rst = 1'b0;
        seed_load = 1'b0;
        enable = 1'b1;
        wait_valid(c);
        check("rst_prio", {8'd0, key_out}, 16'h00E1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
